amba_ram_slave: RTL and testbench

- AMBA-style memory-mapped RAM slave.
- Sits directly downstream of the CPU-side AMBA memory master, alongside the switch/LED slave, on the same read (AR/R) and write (AW/W/B) channels.
- Services one transaction at a time from an internal word-organised RAM.
- Flags misaligned or out-of-window addresses with an error response.

---
 rtl/amba_ram_slave.sv | 131 +++++++++++++
 tb/tb_amba_ram_slave.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/amba_ram_slave.sv
// Word-organised RAM behind AMBA-style AR/R and AW/W/B channels, one transaction at a time.
// Misaligned or out-of-window addresses complete with an error response and never touch the RAM.
module amba_ram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned DEPTH     = 256
) (
    input  logic        Aclk,
    input  logic        Areset,
    input  logic [31:0] ARAddr,
    input  logic        ARValid,
    output logic        ARReady,
    output logic [31:0] RData,
    output logic        RValid,
    output logic        RResp,
    input  logic        RReady,
    input  logic [31:0] AWAddr,
    input  logic        AWValid,
    output logic        AWReady,
    input  logic [31:0] WData,
    input  logic        WValid,
    output logic        WReady,
    output logic        BResp,
    output logic        BValid,
    input  logic        BReady
);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);

    // Valid/ready: a transfer happens on a rising edge where both are high;
    // valid/data from this slave hold until that edge.
    typedef enum logic [1:0] {IDLE, RD_RESP, WR_DATA, WR_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rresp_q, rresp_d;
    logic        bresp_q, bresp_d;
    logic [31:0] mem_q [DEPTH];

    logic [31:0]      rd_off, wr_off;
    logic             rd_ok, wr_ok;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             ar_hs, aw_hs, w_hs, mem_we;

    // Unsigned wrap makes addresses below BASE_ADDR fail the window compare too.
    assign rd_off = ARAddr - BASE_ADDR;
    assign rd_ok  = (rd_off < WIN_BYTES) && (ARAddr[1:0] == 2'b00);
    assign rd_idx = IDX_W'(rd_off >> 2);
    assign wr_off = addr_q - BASE_ADDR;
    assign wr_ok  = (wr_off < WIN_BYTES) && (addr_q[1:0] == 2'b00);
    assign wr_idx = IDX_W'(wr_off >> 2);

    assign aw_hs  = (state_q == IDLE) && AWValid;
    assign ar_hs  = (state_q == IDLE) && !AWValid && ARValid;
    assign w_hs   = (state_q == WR_DATA) && WValid;
    assign mem_we = w_hs && wr_ok;

    always_ff @(posedge Aclk) begin
        if (Areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (AWValid)      state_d = WR_DATA;
                else if (ARValid) state_d = RD_RESP;
            end
            RD_RESP: if (RReady) state_d = IDLE;
            WR_DATA: if (WValid) state_d = WR_RESP;
            WR_RESP: if (BReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        AWReady = 1'b0;
        ARReady = 1'b0;
        WReady  = 1'b0;
        RValid  = 1'b0;
        BValid  = 1'b0;
        case (state_q)
            IDLE: begin
                AWReady = 1'b1;
                ARReady = !AWValid;
            end
            RD_RESP: RValid = 1'b1;
            WR_DATA: WReady = 1'b1;
            WR_RESP: BValid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        bresp_d = bresp_q;
        if (aw_hs) addr_d = AWAddr;
        if (ar_hs) begin
            addr_d  = ARAddr;
            rdata_d = rd_ok ? mem_q[rd_idx] : 32'h0;
            rresp_d = !rd_ok;
        end
        if (w_hs) bresp_d = !wr_ok;
    end

    always_ff @(posedge Aclk) begin
        if (Areset) begin
            addr_q  <= 32'h0;
            rdata_q <= 32'h0;
            rresp_q <= 1'b0;
            bresp_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            bresp_q <= bresp_d;
        end
    end

    // RAM is not cleared by reset, but a reset on the W edge cancels that write.
    always_ff @(posedge Aclk) begin
        if (!Areset && mem_we) mem_q[wr_idx] <= WData;
    end

    assign RData = rdata_q;
    assign RResp = rresp_q;
    assign BResp = bresp_q;
endmodule

// File: tb/tb_amba_ram_slave.sv
// Directed bench for amba_ram_slave: every response is checked against hand-computed values
// with immediate assertions; inputs are driven and outputs sampled on the falling edge.
module tb_amba_ram_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ar_addr, aw_addr, w_data, r_data;
  logic        ar_valid, ar_ready, r_valid, r_resp, r_ready;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_resp, b_valid, b_ready;

  int vectors = 0;
  int miscompares = 0;

  amba_ram_slave #(.BASE_ADDR(32'h0000_1000), .DEPTH(256)) dut (
    .Aclk(clk), .Areset(rst),
    .ARAddr(ar_addr), .ARValid(ar_valid), .ARReady(ar_ready),
    .RData(r_data), .RValid(r_valid), .RResp(r_resp), .RReady(r_ready),
    .AWAddr(aw_addr), .AWValid(aw_valid), .AWReady(aw_ready),
    .WData(w_data), .WValid(w_valid), .WReady(w_ready),
    .BResp(b_resp), .BValid(b_valid), .BReady(b_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full write; during a B stall all other valids are raised and must be ignored.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic exp_resp, input int stall);
    aw_valid = 1'b1;
    aw_addr  = addr;
    #1 chk("aw_ready", aw_ready, 1);
    tick();
    aw_valid = 1'b0;
    w_valid  = 1'b1;
    w_data   = data;
    #1 chk("w_ready", w_ready, 1);
    tick();
    w_valid = 1'b0;
    chk("b_valid", b_valid, 1);
    chk("b_resp", b_resp, exp_resp);
    for (int i = 0; i < stall; i++) begin
      aw_valid = 1'b1;
      ar_valid = 1'b1;
      w_valid  = 1'b1;
      tick();
      chk("b_stall_valid", b_valid, 1);
      chk("b_stall_resp", b_resp, exp_resp);
      chk("b_stall_awready", aw_ready, 0);
      chk("b_stall_arready", ar_ready, 0);
      chk("b_stall_wready", w_ready, 0);
    end
    aw_valid = 1'b0;
    ar_valid = 1'b0;
    w_valid  = 1'b0;
    b_ready  = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("b_valid_clear", b_valid, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_resp, input int stall);
    ar_valid = 1'b1;
    ar_addr  = addr;
    #1 chk("ar_ready", ar_ready, 1);
    tick();
    ar_valid = 1'b0;
    chk("r_valid", r_valid, 1);
    chk("r_data", r_data, exp_data);
    chk("r_resp", r_resp, exp_resp);
    for (int i = 0; i < stall; i++) begin
      aw_valid = 1'b1;
      ar_valid = 1'b1;
      tick();
      chk("r_stall_valid", r_valid, 1);
      chk("r_stall_data", r_data, exp_data);
      chk("r_stall_arready", ar_ready, 0);
      chk("r_stall_awready", aw_ready, 0);
    end
    aw_valid = 1'b0;
    ar_valid = 1'b0;
    r_ready  = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("r_valid_clear", r_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    ar_addr = '0; ar_valid = 1'b0; r_ready = 1'b0;
    aw_addr = '0; aw_valid = 1'b0; w_data = '0; w_valid = 1'b0; b_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_bvalid", b_valid, 0);
    chk("rst_rresp", r_resp, 0);
    chk("rst_bresp", b_resp, 0);
    chk("rst_rdata", r_data, 32'h0);
    chk("rst_wready", w_ready, 0);
    chk("rst_awready", aw_ready, 1);
    chk("rst_arready", ar_ready, 1);
    rst = 1'b0;
    tick();

    // Basic write then read
    do_write(32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 0);
    do_read(32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 0);

    // Window boundaries: last word OK, one past end and one below base are errors
    do_write(32'h0000_13FC, 32'h1234_5678, 1'b0, 0);
    do_read(32'h0000_13FC, 32'h1234_5678, 1'b0, 0);
    do_read(32'h0000_1400, 32'h0, 1'b1, 0);
    do_read(32'h0000_0FFC, 32'h0, 1'b1, 0);
    do_write(32'h0000_1400, 32'hAAAA_0001, 1'b1, 0);
    do_write(32'h0000_0FFC, 32'hAAAA_0002, 1'b1, 0);
    do_read(32'h0000_13FC, 32'h1234_5678, 1'b0, 0);

    // Misaligned write is rejected and leaves word 0 alone
    do_write(32'h0000_1000, 32'h0BAD_F00D, 1'b0, 0);
    do_write(32'h0000_1002, 32'hFFFF_FFFF, 1'b1, 0);
    do_read(32'h0000_1000, 32'h0BAD_F00D, 1'b0, 0);
    do_read(32'h0000_1002, 32'h0, 1'b1, 0);

    // Early WValid in IDLE is not consumed
    w_valid = 1'b1;
    w_data  = 32'hEEEE_EEEE;
    #1 chk("early_w_wready", w_ready, 0);
    tick();
    w_valid = 1'b0;
    do_read(32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 0);

    // Simultaneous AR and AW: write first, read afterwards sees the new data
    do_write(32'h0000_1010, 32'h1111_1111, 1'b0, 0);
    aw_valid = 1'b1; aw_addr = 32'h0000_1010;
    ar_valid = 1'b1; ar_addr = 32'h0000_1010;
    #1 chk("sim_awready", aw_ready, 1);
    chk("sim_arready", ar_ready, 0);
    tick();
    aw_valid = 1'b0;
    w_valid  = 1'b1;
    w_data   = 32'hCAFE_0001;
    #1 chk("sim_wdata_arready", ar_ready, 0);
    tick();
    w_valid = 1'b0;
    chk("sim_bvalid", b_valid, 1);
    chk("sim_bresp", b_resp, 0);
    chk("sim_wresp_arready", ar_ready, 0);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("sim_idle_arready", ar_ready, 1);
    tick();
    ar_valid = 1'b0;
    chk("sim_rvalid", r_valid, 1);
    chk("sim_rdata", r_data, 32'hCAFE_0001);
    chk("sim_rresp", r_resp, 0);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("sim_rvalid_clear", r_valid, 0);

    // Backpressure on R and B for 5 cycles each
    do_read(32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 5);
    do_write(32'h0000_1014, 32'h5555_AAAA, 1'b0, 5);
    do_read(32'h0000_1014, 32'h5555_AAAA, 1'b0, 0);
    do_read(32'h0000_1010, 32'hCAFE_0001, 1'b0, 0);

    // Reset on the W handshake edge: write dropped, no response
    do_write(32'h0000_1008, 32'h7777_0008, 1'b0, 0);
    aw_valid = 1'b1;
    aw_addr  = 32'h0000_1008;
    tick();
    aw_valid = 1'b0;
    w_valid  = 1'b1;
    w_data   = 32'hBAD0_BAD0;
    rst      = 1'b1;
    tick();
    w_valid = 1'b0;
    rst     = 1'b0;
    chk("rst_mid_wready", w_ready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_bvalid", b_valid, 0);
      tick();
    end
    do_read(32'h0000_1008, 32'h7777_0008, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
